spmv_result_writer: RTL and testbench

- Receiving end of the sparse MxV result stream.
- The sequencer raises a result strobe and presents four 16-bit row results per beat from the four compute lanes; this block captures each beat, applies optional ReLU and packs the lanes into one 64-bit word.
- It writes that word into the output BRAM at consecutive addresses and reports completion, beat count, overflow and a checksum to the host side.
- It sits between the sparse MxV core outputs and the result BRAM.

---
 rtl/spmv_result_writer_if.sv | 30 +++
 rtl/spmv_result_writer.sv | 112 +++++++++++
 tb/tb_spmv_result_writer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_result_writer_if.sv
// Result-stream bundle between the sparse MxV sequencer, this writer, the result BRAM and the host.
// master = sequencer/host side, slave = the result writer.
interface spmv_result_writer_if #(
    parameter int ADDR_W = 11
);
    logic              idle;
    logic              res_valid;
    logic [15:0]       res0;
    logic [15:0]       res1;
    logic [15:0]       res2;
    logic [15:0]       res3;
    logic              out_en;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [63:0]       out_din;
    logic [11:0]       beat_count;
    logic              done;
    logic              overflow;
    logic [31:0]       checksum;

    modport master (
        output idle, res_valid, res0, res1, res2, res3,
        input  out_en, out_we, out_addr, out_din, beat_count, done, overflow, checksum
    );

    modport slave (
        input  idle, res_valid, res0, res1, res2, res3,
        output out_en, out_we, out_addr, out_din, beat_count, done, overflow, checksum
    );
endinterface

// File: rtl/spmv_result_writer.sv
// Captures four-lane MxV result beats, optionally applies ReLU, packs them into 64-bit words
// and writes them to consecutive BRAM addresses while tracking count, done, overflow and checksum.
//
// state   | meaning
// IDLE    | after reset; strobes ignored until idle arms the block
// ARMED   | run state cleared, waiting for beat 0
// COLLECT | writing beats, one BRAM write per strobe
// DONE    | NUM_BEATS written; further strobes only set overflow
module spmv_result_writer #(
    parameter int NUM_BEATS = 1024,
    parameter int ADDR_W    = 11,
    parameter int BASE_ADDR = 0,
    parameter int RELU      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    spmv_result_writer_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [11:0]       LAST_COUNT = 12'(NUM_BEATS);

    logic [1:0]        r_state;
    logic              r_en;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_din;
    logic [11:0]       r_beat_count;
    logic              r_done;
    logic              r_overflow;
    logic [31:0]       r_checksum;

    logic [15:0] w_l0, w_l1, w_l2, w_l3;
    logic [31:0] w_sum;
    logic [11:0] w_next_count;
    logic        w_accept;

    function automatic logic [15:0] relu_lane(input logic [15:0] x);
        return ((RELU != 0) && x[15]) ? 16'd0 : x;
    endfunction

    assign w_l0 = relu_lane(bus.res0);
    assign w_l1 = relu_lane(bus.res1);
    assign w_l2 = relu_lane(bus.res2);
    assign w_l3 = relu_lane(bus.res3);

    assign w_sum = {{16{w_l0[15]}}, w_l0} + {{16{w_l1[15]}}, w_l1}
                 + {{16{w_l2[15]}}, w_l2} + {{16{w_l3[15]}}, w_l3};

    assign w_next_count = r_beat_count + 12'd1;

    // Count guard keeps the address inside the run window even if the state were ever wrong.
    assign w_accept = bus.res_valid && ((r_state == S_ARMED) || (r_state == S_COLLECT))
                      && (r_beat_count < LAST_COUNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_en         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_beat_count <= '0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_checksum   <= '0;
        end else if (bus.idle) begin
            r_state      <= S_ARMED;
            r_en         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= BASE;
            r_beat_count <= '0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_checksum   <= '0;
        end else begin
            r_en <= 1'b0;
            r_we <= 1'b0;
            if (w_accept) begin
                r_en         <= 1'b1;
                r_we         <= 1'b1;
                r_addr       <= BASE + ADDR_W'(r_beat_count);
                r_din        <= {w_l3, w_l2, w_l1, w_l0};
                r_beat_count <= w_next_count;
                r_checksum   <= r_checksum + w_sum;
                if (w_next_count == LAST_COUNT) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_COLLECT;
                end
            end else if ((r_state == S_DONE) && bus.res_valid) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.out_en     = r_en;
    assign bus.out_we     = r_we;
    assign bus.out_addr   = r_addr;
    assign bus.out_din    = r_din;
    assign bus.beat_count = r_beat_count;
    assign bus.done       = r_done;
    assign bus.overflow   = r_overflow;
    assign bus.checksum   = r_checksum;

endmodule

// File: tb/tb_spmv_result_writer.sv
// Directed bench for spmv_result_writer: three instances (default, RELU, 8-beat at base 16).
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_spmv_result_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def, rst_relu, rst_b8;

    spmv_result_writer_if #(.ADDR_W(11)) if_def ();
    spmv_result_writer_if #(.ADDR_W(11)) if_relu ();
    spmv_result_writer_if #(.ADDR_W(11)) if_b8 ();

    spmv_result_writer #(.NUM_BEATS(1024), .ADDR_W(11), .BASE_ADDR(0), .RELU(0)) u_def (
        .clk(clk), .rst(rst_def), .bus(if_def.slave));
    spmv_result_writer #(.NUM_BEATS(16), .ADDR_W(11), .BASE_ADDR(0), .RELU(1)) u_relu (
        .clk(clk), .rst(rst_relu), .bus(if_relu.slave));
    spmv_result_writer #(.NUM_BEATS(8), .ADDR_W(11), .BASE_ADDR(16), .RELU(0)) u_b8 (
        .clk(clk), .rst(rst_b8), .bus(if_b8.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] r0, r1, r2, r3;
        logic        gap;
        logic [63:0] din_relu;
        logic [63:0] din_raw;
        logic [31:0] sum_relu;
        logic [31:0] sum_raw;
    } vec_t;

    vec_t vecs [4];
    int   gaps [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] cks_def, cks_relu;
        logic [63:0] din_exp;

        vecs[0] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 1'b1,
                    64'h0001_7FFF_0000_0000, 64'h0001_7FFF_8000_FFFF, 32'h0000_8000, 32'hFFFF_FFFF};
        vecs[1] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 1'b0,
                    64'h0040_0030_0020_0010, 64'h0040_0030_0020_0010, 32'h0000_00A0, 32'h0000_00A0};
        vecs[2] = '{16'h8001, 16'hFFFE, 16'h0000, 16'h7FFF, 1'b1,
                    64'h7FFF_0000_0000_0000, 64'h7FFF_0000_FFFE_8001, 32'h0000_7FFF, 32'hFFFF_FFFE};
        vecs[3] = '{16'h1234, 16'hABCD, 16'hFFFF, 16'h4321, 1'b0,
                    64'h4321_0000_0000_1234, 64'h4321_FFFF_ABCD_1234, 32'h0000_5555, 32'h0000_0121};
        gaps = '{0, 2, 1, 3, 0, 1, 2, 0};

        rst_def = 1'b0; rst_relu = 1'b0; rst_b8 = 1'b0;
        if_def.idle = 0;  if_def.res_valid = 0;
        if_def.res0 = 0;  if_def.res1 = 0;  if_def.res2 = 0;  if_def.res3 = 0;
        if_relu.idle = 0; if_relu.res_valid = 0;
        if_relu.res0 = 0; if_relu.res1 = 0; if_relu.res2 = 0; if_relu.res3 = 0;
        if_b8.idle = 0;   if_b8.res_valid = 0;
        if_b8.res0 = 0;   if_b8.res1 = 0;   if_b8.res2 = 0;   if_b8.res3 = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_en", if_def.out_en, 0);
        chk("rst_we", if_def.out_we, 0);
        chk("rst_addr", if_def.out_addr, 0);
        chk("rst_din", if_def.out_din, 0);
        chk("rst_count", if_def.beat_count, 0);
        chk("rst_done", if_def.done, 0);
        chk("rst_ovf", if_def.overflow, 0);
        chk("rst_cks", if_def.checksum, 0);
        rst_def = 1'b1; rst_relu = 1'b1; rst_b8 = 1'b1;

        // Strobes in IDLE are ignored
        if_def.res_valid = 1; if_def.res0 = 16'h0055;
        @(negedge clk);
        chk("idle_ign_we", if_def.out_we, 0);
        chk("idle_ign_count", if_def.beat_count, 0);
        chk("idle_ign_ovf", if_def.overflow, 0);
        if_def.res_valid = 0;

        // Four consecutive beats, lanes 1,2,3,4 incrementing
        if_def.idle = 1;
        @(negedge clk);
        if_def.idle = 0;
        chk("arm_we", if_def.out_we, 0);
        chk("arm_addr", if_def.out_addr, 0);
        cks_def = 0;
        for (int k = 0; k < 4; k++) begin
            if_def.res_valid = 1;
            if_def.res0 = 16'(1 + k); if_def.res1 = 16'(2 + k);
            if_def.res2 = 16'(3 + k); if_def.res3 = 16'(4 + k);
            cks_def = cks_def + 32'(10 + 4 * k);
            @(negedge clk);
            din_exp = {16'(4 + k), 16'(3 + k), 16'(2 + k), 16'(1 + k)};
            chk("b4_we", if_def.out_we, 1);
            chk("b4_en", if_def.out_en, 1);
            chk("b4_addr", if_def.out_addr, 64'(k));
            chk("b4_din", if_def.out_din, din_exp);
            chk("b4_count", if_def.beat_count, 64'(k + 1));
            chk("b4_cks", if_def.checksum, cks_def);
            if (k == 0) chk("b4_din0", if_def.out_din, 64'h0004_0003_0002_0001);
        end
        if_def.res_valid = 0;
        @(negedge clk);
        chk("b4_gap_we", if_def.out_we, 0);
        chk("b4_gap_addr", if_def.out_addr, 3);
        chk("b4_gap_din", if_def.out_din, 64'h0007_0006_0005_0004);
        chk("b4_final_count", if_def.beat_count, 4);
        chk("b4_final_cks", if_def.checksum, 64);
        chk("b4_done", if_def.done, 0);

        // Lane table on RELU=1 and RELU=0 instances
        if_def.idle = 1; if_relu.idle = 1;
        @(negedge clk);
        if_def.idle = 0; if_relu.idle = 0;
        cks_def = 0; cks_relu = 0;
        for (int i = 0; i < 4; i++) begin
            if_def.res_valid = 1;   if_relu.res_valid = 1;
            if_def.res0 = vecs[i].r0;  if_relu.res0 = vecs[i].r0;
            if_def.res1 = vecs[i].r1;  if_relu.res1 = vecs[i].r1;
            if_def.res2 = vecs[i].r2;  if_relu.res2 = vecs[i].r2;
            if_def.res3 = vecs[i].r3;  if_relu.res3 = vecs[i].r3;
            cks_def  = cks_def  + vecs[i].sum_raw;
            cks_relu = cks_relu + vecs[i].sum_relu;
            @(negedge clk);
            chk("tbl_relu_we", if_relu.out_we, 1);
            chk("tbl_relu_din", if_relu.out_din, vecs[i].din_relu);
            chk("tbl_relu_cks", if_relu.checksum, cks_relu);
            chk("tbl_raw_din", if_def.out_din, vecs[i].din_raw);
            chk("tbl_raw_cks", if_def.checksum, cks_def);
            if_def.res_valid = 0; if_relu.res_valid = 0;
            if (vecs[i].gap) begin
                @(negedge clk);
                chk("tbl_gap_we", if_relu.out_we, 0);
                chk("tbl_gap_din", if_relu.out_din, vecs[i].din_relu);
                chk("tbl_gap_cks", if_relu.checksum, cks_relu);
            end
        end

        // 8-beat run at base 16 with gaps, then overflow
        if_b8.idle = 1;
        @(negedge clk);
        if_b8.idle = 0;
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                if_b8.res_valid = 0;
                @(negedge clk);
                chk("b8_gap_we", if_b8.out_we, 0);
                chk("b8_gap_count", if_b8.beat_count, 64'(k));
            end
            if_b8.res_valid = 1;
            if_b8.res0 = 16'(k);
            @(negedge clk);
            chk("b8_we", if_b8.out_we, 1);
            chk("b8_addr", if_b8.out_addr, 64'(16 + k));
            chk("b8_done", if_b8.done, (k == 7) ? 64'd1 : 64'd0);
            chk("b8_count", if_b8.beat_count, 64'(k + 1));
        end
        if_b8.res_valid = 0;
        @(negedge clk);
        chk("b8_done_sticky", if_b8.done, 1);
        chk("b8_cks", if_b8.checksum, 28);
        if_b8.res_valid = 1;
        @(negedge clk);
        chk("b8_ovf_we", if_b8.out_we, 0);
        chk("b8_ovf", if_b8.overflow, 1);
        chk("b8_ovf_count", if_b8.beat_count, 8);
        chk("b8_ovf_addr", if_b8.out_addr, 23);
        if_b8.res_valid = 0;
        @(negedge clk);
        chk("b8_ovf_sticky", if_b8.overflow, 1);

        // idle and strobe together mid-run
        if_b8.idle = 1;
        @(negedge clk);
        if_b8.idle = 0;
        if_b8.res_valid = 1; if_b8.res0 = 16'd3;
        repeat (2) @(negedge clk);
        chk("coll_pre_count", if_b8.beat_count, 2);
        if_b8.idle = 1;
        @(negedge clk);
        if_b8.idle = 0;
        chk("coll_we", if_b8.out_we, 0);
        chk("coll_count", if_b8.beat_count, 0);
        chk("coll_addr", if_b8.out_addr, 16);
        chk("coll_cks", if_b8.checksum, 0);
        chk("coll_ovf", if_b8.overflow, 0);
        if_b8.res0 = 16'd5;
        @(negedge clk);
        chk("coll_next_we", if_b8.out_we, 1);
        chk("coll_next_addr", if_b8.out_addr, 16);
        chk("coll_next_count", if_b8.beat_count, 1);
        chk("coll_next_cks", if_b8.checksum, 5);

        // Asynchronous reset mid-COLLECT
        @(negedge clk);
        chk("ar_pre_we", if_b8.out_we, 1);
        #2 rst_b8 = 1'b0;
        #1;
        chk("ar_en", if_b8.out_en, 0);
        chk("ar_we", if_b8.out_we, 0);
        chk("ar_addr", if_b8.out_addr, 0);
        chk("ar_din", if_b8.out_din, 0);
        chk("ar_count", if_b8.beat_count, 0);
        chk("ar_cks", if_b8.checksum, 0);
        @(negedge clk);
        rst_b8 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("ar_ign_we", if_b8.out_we, 0);
            chk("ar_ign_count", if_b8.beat_count, 0);
        end
        if_b8.res_valid = 0;
        if_b8.idle = 1;
        @(negedge clk);
        if_b8.idle = 0;
        if_b8.res_valid = 1;
        @(negedge clk);
        chk("ar_rearm_we", if_b8.out_we, 1);
        chk("ar_rearm_addr", if_b8.out_addr, 16);
        if_b8.res_valid = 0;

        // Full default run of 1024 back-to-back beats
        if_def.idle = 1;
        @(negedge clk);
        if_def.idle = 0;
        if_def.res1 = 0; if_def.res2 = 0; if_def.res3 = 0;
        for (int k = 0; k < 1024; k++) begin
            if_def.res_valid = 1;
            if_def.res0 = 16'(k);
            @(negedge clk);
            chk("full_we", if_def.out_we, 1);
            chk("full_addr", if_def.out_addr, 64'(k));
            chk("full_done", if_def.done, (k == 1023) ? 64'd1 : 64'd0);
        end
        if_def.res_valid = 0;
        @(negedge clk);
        chk("full_count", if_def.beat_count, 1024);
        chk("full_ovf", if_def.overflow, 0);
        chk("full_done_sticky", if_def.done, 1);
        chk("full_we_off", if_def.out_we, 0);
        chk("full_addr_hold", if_def.out_addr, 1023);
        if_def.res_valid = 1;
        @(negedge clk);
        if_def.res_valid = 0;
        chk("full_ovf_set", if_def.overflow, 1);
        chk("full_ovf_we", if_def.out_we, 0);
        chk("full_ovf_count", if_def.beat_count, 1024);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
